// File: rtl/calc_pkg.sv
// Shared definitions for the stack-calculator front end: command codes,
// bus widths and the command FSM state encoding.
package calc_pkg;

    localparam int unsigned BTN_W  = 4;
    localparam int unsigned SW_W   = 8;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned ACT_W  = 2;

    // {mode[1:0], action[1:0]}
    localparam logic [CODE_W-1:0] CMD_PUSH = 4'b0001;
    localparam logic [CODE_W-1:0] CMD_POP  = 4'b0010;
    localparam logic [CODE_W-1:0] CMD_ADD  = 4'b0101;
    localparam logic [CODE_W-1:0] CMD_SUB  = 4'b0110;
    localparam logic [CODE_W-1:0] CMD_TOP  = 4'b1001;
    localparam logic [CODE_W-1:0] CMD_CLR  = 4'b1010;
    localparam logic [CODE_W-1:0] CMD_INC  = 4'b1101;
    localparam logic [CODE_W-1:0] CMD_DEC  = 4'b1110;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } cmd_state_t;

endpackage

// File: rtl/btn_sync_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one button.
module btn_sync_debounce #(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level
);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // The level only flips after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], in};
            if (sync[1] != level) begin
                if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/btn_cmd_decoder.sv
// Debounces the push buttons and turns each action-button press into one
// {mode, action} command with a switch operand, delivered by valid/ready.
module btn_cmd_decoder
    import calc_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BTN_W-1:0]  btns,
    input  logic [SW_W-1:0]   swtchs,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic [CODE_W-1:0] cmd_code,
    output logic [SW_W-1:0]   cmd_data,
    output logic              cmd_drop,
    output logic [BTN_W-1:0]  btn_level
);

    for (genvar i = 0; i < BTN_W; i++) begin : g_db
        btn_sync_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .in    (btns[i]),
            .level (btn_level[i])
        );
    end

    logic [SW_W-1:0]   sw_s1;
    logic [SW_W-1:0]   sw_s2;
    logic [ACT_W-1:0]  act_q;
    logic [ACT_W-1:0]  rise;
    cmd_state_t        state;
    cmd_state_t        state_nx;
    logic              valid_nx;
    logic [CODE_W-1:0] code_nx;
    logic [SW_W-1:0]   data_nx;
    logic              drop_nx;

    assign rise = btn_level[ACT_W-1:0] & ~act_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1     <= '0;
            sw_s2     <= '0;
            act_q     <= '0;
            state     <= ST_IDLE;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            cmd_data  <= '0;
            cmd_drop  <= 1'b0;
        end else begin
            sw_s1     <= swtchs;
            sw_s2     <= sw_s1;
            act_q     <= btn_level[ACT_W-1:0];
            state     <= state_nx;
            cmd_valid <= valid_nx;
            cmd_code  <= code_nx;
            cmd_data  <= data_nx;
            cmd_drop  <= drop_nx;
        end
    end

    // btn1 has priority on a simultaneous press; the lost btn0 press is flagged.
    always_comb begin
        state_nx = state;
        valid_nx = cmd_valid;
        code_nx  = cmd_code;
        data_nx  = cmd_data;
        drop_nx  = cmd_drop;
        case (state)
            ST_IDLE: begin
                if (|rise) begin
                    state_nx = ST_VALID;
                    valid_nx = 1'b1;
                    code_nx  = {btn_level[3:2], rise[1], rise[0] & ~rise[1]};
                    data_nx  = sw_s2;
                    drop_nx  = &rise;
                end
            end
            ST_VALID: begin
                if (|rise) begin
                    drop_nx = 1'b1;
                end
                if (cmd_ready) begin
                    state_nx = ST_IDLE;
                    valid_nx = 1'b0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule
